// File: rtl/hgcal_pkg.sv
// hgcal_pkg: shared constants, state encoding and the reference quantizer
// used by the HGCAL input packer and its testbench.
package hgcal_pkg;

    // Bits per quantized feature code.
    localparam int unsigned QBITS = 2;

    // Default quantization thresholds for 8-bit charge samples.
    localparam int unsigned DEF_T1 = 64;
    localparam int unsigned DEF_T2 = 128;
    localparam int unsigned DEF_T3 = 192;

    // Packer state encoding.
    localparam logic [1:0] StFill = 2'd0;  // accepting beats into the fill bank
    localparam logic [1:0] StHold = 2'd1;  // completed frame waiting for the output bank
    localparam logic [1:0] StDrop = 2'd2;  // discarding overrun beats until s_last

    // Map a sample to a 2-bit code against three ascending thresholds.
    function automatic logic [QBITS-1:0] quantize(input int unsigned x,
                                                  input int unsigned t1,
                                                  input int unsigned t2,
                                                  input int unsigned t3);
        if (x >= t3) begin
            return 2'd3;
        end else if (x >= t2) begin
            return 2'd2;
        end else if (x >= t1) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/hgcal_input_packer_quantizer.sv
// hgcal_quantizer: combinational threshold compare of one unsigned sample.
//   x_i    : IN_WIDTH-bit unsigned charge sample
//   code_o : 2-bit quantized code (0..3)
module hgcal_quantizer
    import hgcal_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned T1       = DEF_T1,
    parameter int unsigned T2       = DEF_T2,
    parameter int unsigned T3       = DEF_T3
) (
    input  logic [IN_WIDTH-1:0] x_i,
    output logic [QBITS-1:0]    code_o
);

    logic [31:0] x_ext;

    always_comb begin
        x_ext  = 32'(x_i);
        code_o = quantize(x_ext, T1, T2, T3);
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantizes a stream of charge samples to 2-bit codes and
// packs each frame into a flat vector for the layer-0 neuron LUTs. A fill bank
// collects the next frame while the output bank holds the previous one.
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready       : input beat handshake
//   s_data, s_last        : sample and end-of-frame marker
//   m_valid/m_ready       : packed frame handshake
//   m_data                : feature i at bits [2i+1:2i]
//   err_short, err_long   : one-cycle pulses for padded / overrun frames
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int unsigned N_FEATURES = 48,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned T1         = DEF_T1,
    parameter int unsigned T2         = DEF_T2,
    parameter int unsigned T3         = DEF_T3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [IN_WIDTH-1:0]         s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [QBITS*N_FEATURES-1:0] m_data,
    output logic                        err_short,
    output logic                        err_long
);

    localparam int unsigned IdxW = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam int unsigned VecW = QBITS * N_FEATURES;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_FEATURES - 1);

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [VecW-1:0] fill_q, fill_d;
    logic [VecW-1:0] m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            drop_pend_q, drop_pend_d;
    logic            err_short_q, err_short_d;
    logic            err_long_q, err_long_d;

    logic [QBITS-1:0] code;
    logic [VecW-1:0]  frame_word;
    logic             accept, at_last, out_free, overrun;

    hgcal_quantizer #(
        .IN_WIDTH (IN_WIDTH),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3)
    ) u_quant (
        .x_i    (s_data),
        .code_o (code)
    );

    // Ready is low only in HOLD, and while reset is asserted.
    assign s_ready   = rst_n && (state_q != StHold);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    assign accept   = s_valid && s_ready;
    assign at_last  = (idx_q == LastIdx);
    assign out_free = !m_valid_q || m_ready;
    assign overrun  = at_last && !s_last;

    // Current slot takes the new code; slots above it are zeroed so a short
    // frame never carries codes from an earlier frame.
    always_comb begin
        frame_word = '0;
        for (int i = 0; i < int'(N_FEATURES); i++) begin
            if (i < int'(idx_q)) begin
                frame_word[QBITS*i +: QBITS] = fill_q[QBITS*i +: QBITS];
            end else if (i == int'(idx_q)) begin
                frame_word[QBITS*i +: QBITS] = code;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q && !m_ready;
        drop_pend_d = drop_pend_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        case (state_q)
            StFill: begin
                if (accept) begin
                    fill_d = frame_word;
                    if (at_last || s_last) begin
                        idx_d       = '0;
                        err_long_d  = overrun;
                        err_short_d = s_last && !at_last;
                        if (out_free) begin
                            m_data_d  = frame_word;
                            m_valid_d = 1'b1;
                            state_d   = overrun ? StDrop : StFill;
                        end else begin
                            state_d     = StHold;
                            drop_pend_d = overrun;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StHold: begin
                if (out_free) begin
                    m_data_d    = fill_q;
                    m_valid_d   = 1'b1;
                    state_d     = drop_pend_q ? StDrop : StFill;
                    drop_pend_d = 1'b0;
                end
            end
            StDrop: begin
                if (accept && s_last) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            idx_q       <= '0;
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            drop_pend_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            drop_pend_q <= drop_pend_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

endmodule

// File: doc/hgcal_input_packer.md
# hgcal_input_packer

Front-end stage of the HGCAL autoencoder LUT network. It accepts raw per-cell charge samples one per beat over a valid/ready stream and quantizes each to a 2-bit code with three fixed thresholds. It packs a full frame into the flat input vector consumed by the layer-0 neuron LUTs, where each neuron takes an 8-bit slice of four 2-bit features. The block is double-buffered: the next frame fills while the previous one is held for the network pipeline.

## Interface
- N_FEATURES, 48: features per frame; output vector width is 2*N_FEATURES.
- IN_WIDTH, 8: unsigned sample width.
- T1, 64; T2, 128; T3, 192: quantization thresholds. Legal only if T1 < T2 < T3 < 2**IN_WIDTH.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  IN_WIDTH  unsigned charge sample.
- s_last  input  1  final beat of a frame.
- m_valid  output  1  packed frame available.
- m_ready  input  1  downstream consumes frame when m_valid && m_ready.
- m_data  output  2*N_FEATURES  feature i occupies bits [2i+1:2i].
- err_short  output  1  one-cycle pulse: frame ended early, padded.
- err_long  output  1  one-cycle pulse: frame overran N_FEATURES, excess discarded.

## Operation
- Quantization of sample x: code 3 if x>=T3, else 2 if x>=T2, else 1 if x>=T1, else 0. The quantizer is combinational ahead of the fill register.
- Fill bank: 2*N_FEATURES register plus index counter idx, width $clog2(N_FEATURES), reset 0. An accepted beat writes its code to slot idx.
- Output bank: m_data register plus m_valid flag.
- A frame completes on an accepted beat with idx==N_FEATURES-1, or on an accepted beat with s_last.
  - On completion, slots above the written index are forced to code 0. Unwritten slots never leak a previous frame.
  - idx returns to 0.
- State machine FILL / HOLD / DROP, reset FILL.
  - FILL: s_ready=1. On completion, the fill bank transfers to the output bank if the output bank is free this cycle (m_valid==0, or m_ready==1). Otherwise go to HOLD.
  - On completion at idx==N_FEATURES-1 without s_last: pulse err_long and go to DROP. If the output bank is busy, go to HOLD first; the drop is remembered and HOLD exits to DROP.
  - On completion via s_last at idx<N_FEATURES-1: pulse err_short and stay in FILL.
  - HOLD: s_ready=0. When the output bank frees, transfer and go to FILL, or to DROP if a drop is pending.
  - DROP: s_ready=1, beats are discarded. The beat with s_last returns the machine to FILL. No error pulses in DROP.
- Simultaneous events:
  - Completion on the same cycle as m_ready consumption: the new frame is loaded and m_valid stays 1 with no bubble.
  - An s_last beat at idx==N_FEATURES-1 is a normal frame, with no error.
- Reset mid-operation: the partial frame is discarded and idx=0, state=FILL, m_valid=0, m_data=0, err_*=0. s_ready is 0 only while rst_n is low.

## Timing
- Completion beat accepted at cycle t: m_valid=1 with the new m_data at t+1, if the output bank is free.
- Sustained throughput is one frame per N_FEATURES cycles with m_ready held high. There are no bubbles between frames.
- m_data and m_valid are stable while m_valid && !m_ready. m_valid deasserts only after consumption.
- err_short and err_long are registered and assert at t+1, aligned with m_valid of the affected frame.
- s_ready is a registered state decode, with no combinational path from m_ready. HOLD exits to FILL on the cycle after the output bank frees.

## Structure
- Package hgcal_pkg holds:
  - the FILL/HOLD/DROP state enum;
  - QBITS=2 and the default threshold constants;
  - a function quantize(x, t1, t2, t3), shared with the reference model.
- One sub-module, hgcal_quantizer: a combinational IN_WIDTH to 2 threshold compare, instantiated once on s_data.

## Test plan
Bench runs N_FEATURES=4 with default thresholds unless stated.
1. Reset, then frame s_data=10,70,130,200 with s_last on the 4th beat and m_ready=1. Required: m_data=8'b11_10_01_00, one cycle after the last beat; no error pulses.
2. Boundary samples 63,64,191,192. Required: codes 0,1,2,3, so m_data=8'b11_10_01_00.
3. Short frame 200,200 with s_last on beat 2. Required: m_data=8'b00_00_11_11, err_short pulses once, and the next frame starts at slot 0.
4. Long frame of 6 beats, all 130, s_last on beat 6. Required: m_data=8'b10_10_10_10 and err_long one pulse. Beats 5–6 are dropped; the following frame packs correctly.
5. Back-pressure: m_ready=0 while two frames arrive. Required: first frame held stable; s_ready drops after the second frame completes. Raising m_ready yields both frames in order on consecutive cycles.
6. Assert rst_n low mid-frame after 2 beats, then release. Required: m_valid=0, m_data=0, and a fresh 4-beat frame packs from slot 0.
